// File: rtl/coax_tx_sequencer.sv
// Frame sequencer in front of coax_tx: buffers host words in a FIFO and, on start,
// feeds the words present at that moment as one back-to-back frame, then enforces an inter-frame gap.
module coax_tx_sequencer #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned GAP_CLOCKS   = 64,
  parameter int unsigned LOAD_HOLDOFF = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] in_data,
  input  logic       in_push,
  output logic       in_full,
  output logic       in_empty,
  output logic       overflow,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [9:0] tx_data,
  output logic       tx_load,
  input  logic       tx_full,
  input  logic       tx_active
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned HW = (LOAD_HOLDOFF < 2) ? 1 : $clog2(LOAD_HOLDOFF);
  localparam int unsigned GW = (GAP_CLOCKS < 2) ? 1 : $clog2(GAP_CLOCKS);
  localparam int unsigned HOLD_INIT = (LOAD_HOLDOFF == 0) ? 0 : LOAD_HOLDOFF - 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_HI,
    LOAD_LO,
    WAIT_FULL,
    WAIT_END,
    GAP
  } state_t;

  state_t state, state_d;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [LW-1:0] remaining, remaining_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic          seen_active, seen_d;
  logic          load_d;
  logic [9:0]    data_d;
  logic          pop, push_ok, fifo_full;

  assign fifo_full = (level == LW'(DEPTH));
  assign pop       = (state == LOAD_HI);
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign push_ok   = in_push && (!fifo_full || pop);
  assign in_full   = fifo_full;
  assign in_empty  = (level == '0);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= in_push && !push_ok;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      level <= level + LW'(1);
      else if (!push_ok && pop) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      remaining   <= '0;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      seen_active <= 1'b0;
      tx_load     <= 1'b0;
      tx_data     <= '0;
    end else begin
      state       <= state_d;
      remaining   <= remaining_d;
      hold_cnt    <= hold_d;
      gap_cnt     <= gap_d;
      seen_active <= seen_d;
      tx_load     <= load_d;
      tx_data     <= data_d;
    end
  end

  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    hold_d      = hold_cnt;
    gap_d       = gap_cnt;
    seen_d      = seen_active;
    load_d      = 1'b0;
    data_d      = tx_data;
    done        = 1'b0;

    // Remember any tx_active high seen since the frame's first load.
    if (state != IDLE) seen_d = seen_active | tx_active;

    case (state)
      IDLE: begin
        if (start && (level != '0)) begin
          remaining_d = level;
          seen_d      = 1'b0;
          state_d     = LOAD_HI;
        end
      end
      LOAD_HI: begin
        data_d      = mem[rd_ptr];
        load_d      = 1'b1;
        remaining_d = remaining - LW'(1);
        hold_d      = HW'(HOLD_INIT);
        state_d     = LOAD_LO;
      end
      LOAD_LO: begin
        if (hold_cnt == '0) state_d = (remaining == '0) ? WAIT_END : WAIT_FULL;
        else                hold_d  = hold_cnt - HW'(1);
      end
      WAIT_FULL: begin
        if (!tx_full) state_d = LOAD_HI;
      end
      WAIT_END: begin
        if (seen_active && !tx_active) begin
          gap_d   = GW'(GAP_CLOCKS - 1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          gap_d = gap_cnt - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coax_tx_sequencer.sv
// Bench for coax_tx_sequencer: a behavioural coax_tx line model plus a word-queue
// reference for frame contents, overflow and gap timing.
module tb_coax_tx_sequencer;

  localparam int DEPTH = 8;
  localparam int GAPC  = 12;
  localparam int HOLD  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] in_data = '0;
  logic       in_push = 1'b0;
  logic       start = 1'b0;
  logic       tx_full = 1'b0;
  logic       tx_active = 1'b0;
  logic       in_full, in_empty, overflow, busy, done, tx_load;
  logic [9:0] tx_data;

  coax_tx_sequencer #(.DEPTH(DEPTH), .GAP_CLOCKS(GAPC), .LOAD_HOLDOFF(HOLD)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_push(in_push),
    .in_full(in_full), .in_empty(in_empty), .overflow(overflow), .start(start),
    .busy(busy), .done(done), .tx_data(tx_data), .tx_load(tx_load),
    .tx_full(tx_full), .tx_active(tx_active)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line model: holding register + shifter; a frame is start seq, words, end seq.
  int cyc = 0;
  always @(posedge clk) cyc++;

  int         cpb = 8;
  logic       hold_valid = 1'b0, shifting = 1'b0, tailing = 1'b0, active_m = 1'b0, prev_load = 1'b0;
  logic [9:0] hold_word = '0;
  int         shift_cnt = 0, tail_cnt = 0;
  logic [9:0] load_q[$], serial_q[$], exp_fifo[$], frame_exp[$];
  int fall_cyc = 0, done_cyc = 0, done_cnt = 0, active_rises = 0;
  int last_load_cyc = -100, spacing_viol = 0, width_viol = 0;

  always @(negedge clk) begin
    if (reset) begin
      hold_valid = 1'b0; shifting = 1'b0; tailing = 1'b0; active_m = 1'b0; prev_load = 1'b0;
      tx_full = 1'b0; tx_active = 1'b0;
    end else begin
      if (tx_load) begin
        load_q.push_back(tx_data);
        if (prev_load) width_viol++;
        if (cyc - last_load_cyc < 2 + HOLD) spacing_viol++;
        last_load_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (shifting) begin
        shift_cnt--;
        if (shift_cnt == 0) shifting = 1'b0;
      end else if (tailing) begin
        tail_cnt--;
        if (tail_cnt == 0) begin tailing = 1'b0; active_m = 1'b0; fall_cyc = cyc; end
      end
      if (!shifting && !tailing && hold_valid) begin
        if (!active_m) begin active_m = 1'b1; active_rises++; shift_cnt = 14 * cpb; end
        else shift_cnt = 11 * cpb;
        shifting = 1'b1;
        serial_q.push_back(hold_word);
        hold_valid = 1'b0;
      end else if (!shifting && !tailing && active_m) begin
        tailing = 1'b1; tail_cnt = 3 * cpb;
      end
      if (prev_load && !tx_load) begin hold_valid = 1'b1; hold_word = tx_data; end
      prev_load = tx_load;
      tx_full = hold_valid;
      tx_active = active_m;
    end
  end

  task automatic push_word(input logic [9:0] w);
    logic was_full;
    @(negedge clk); #1;
    in_data = w; in_push = 1'b1;
    was_full = (exp_fifo.size() == DEPTH);
    if (!was_full) exp_fifo.push_back(w);
    @(negedge clk); #1;
    in_push = 1'b0;
    check("overflow", overflow, was_full);
  endtask

  task automatic start_frame();
    frame_exp = exp_fifo;
    exp_fifo = {};
    load_q = {}; serial_q = {};
    done_cnt = 0; active_rises = 0; spacing_viol = 0; width_viol = 0; last_load_cyc = -100;
    @(negedge clk); #1; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic finish_frame(input string tag);
    bit got = 0;
    logic [9:0] o;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk); #1;
      if (done_cnt > 0) got = 1;
    end
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_busy_in_done"}, busy, 1);
    @(negedge clk); #1;
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_gap"}, done_cyc - fall_cyc, GAPC);
    check({tag, "_nloads"}, load_q.size(), frame_exp.size());
    check({tag, "_nserial"}, serial_q.size(), frame_exp.size());
    for (int i = 0; i < frame_exp.size(); i++) begin
      o = 'x;
      if (i < load_q.size()) o = load_q[i];
      check({tag, "_load_word"}, o, frame_exp[i]);
      o = 'x;
      if (i < serial_q.size()) o = serial_q[i];
      check({tag, "_line_word"}, o, frame_exp[i]);
    end
    check({tag, "_active_rises"}, active_rises, 1);
    check({tag, "_spacing"}, spacing_viol, 0);
    check({tag, "_width"}, width_viol, 0);
  endtask

  initial begin
    int busy_seen, n;
    bit got;
    // Reset values
    @(negedge clk); #1;
    check("rst_tx_load", tx_load, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_in_empty", in_empty, 1);
    check("rst_in_full", in_full, 0);
    @(negedge clk); #1; reset = 1'b0;

    // Single word
    push_word(10'h3A5);
    start_frame();
    finish_frame("single");
    check("single_empty", in_empty, 1);

    // Three words back to back
    cpb = 8;
    push_word(10'h001); push_word(10'h002); push_word(10'h003);
    start_frame();
    finish_frame("three");

    // Word pushed during transmission belongs to the next frame
    push_word(10'($urandom_range(0, 1023)));
    push_word(10'($urandom_range(0, 1023)));
    start_frame();
    repeat (20) @(negedge clk);
    push_word(10'($urandom_range(0, 1023)));
    finish_frame("split1");
    check("split_not_empty", in_empty, 0);
    check("split_not_full", in_full, 0);
    start_frame();
    finish_frame("split2");

    // Overflow on DEPTH+1 pushes
    for (int i = 0; i < DEPTH + 1; i++) push_word(10'($urandom_range(0, 1023)));
    check("ovf_in_full", in_full, 1);
    start_frame();
    finish_frame("fullframe");
    check("fullframe_empty", in_empty, 1);

    // Start with empty FIFO
    load_q = {}; done_cnt = 0; busy_seen = 0;
    @(negedge clk); #1; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_seen++;
      @(negedge clk); #1;
    end
    check("empty_busy", busy_seen, 0);
    check("empty_loads", load_q.size(), 0);
    check("empty_done", done_cnt, 0);

    // Asynchronous reset while waiting on tx_full
    cpb = 8;
    for (int i = 0; i < 4; i++) push_word(10'($urandom_range(0, 1023)));
    start_frame();
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk); #1;
      if (load_q.size() >= 2) got = 1;
    end
    check("rst_mid_two_loads", got, 1);
    repeat (6) @(negedge clk);
    #1;
    check("rst_mid_tx_full", tx_full, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_tx_load", tx_load, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_in_empty", in_empty, 1);
    @(negedge clk); #1;
    reset = 1'b0;
    exp_fifo = {};
    for (int i = 0; i < 3; i++) push_word(10'($urandom_range(0, 1023)));
    start_frame();
    finish_frame("after_rst");

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      cpb = $urandom_range(2, 8);
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) push_word(10'($urandom_range(0, 1023)));
      start_frame();
      finish_frame("rand");
      check("rand_empty", in_empty, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
